// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: operation codes, FSM state
// encoding and iteration bounds. The control decoder imports the same op codes.
package mdu_pkg;

  localparam int MDU_DATA_WIDTH = 32;
  localparam int ITER_LAST      = MDU_DATA_WIDTH - 1;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } mdu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_FIX  = 2'b10,
    ST_DONE = 2'b11
  } mdu_state_e;

  function automatic logic op_is_div(input logic [1:0] op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

  function automatic logic op_is_signed(input logic [1:0] op);
    return (op == OP_MULT) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/mult_div_unit_twos_negate.sv
// Conditional two's-complement: passes the value through, or negates it when
// i_neg is set. Used for operand magnitudes and final sign correction.
module twos_negate #(
  parameter int WIDTH = 32
) (
  input  logic             i_neg,
  input  logic [WIDTH-1:0] i_val,
  output logic [WIDTH-1:0] o_val
);

  assign o_val = i_neg ? ((~i_val) + WIDTH'(1)) : i_val;

endmodule

// File: rtl/mult_div_unit.sv
// Iterative radix-2 multiply/divide unit with architectural HI/LO registers.
// Start/Busy/Done handshake: Start is sampled only in IDLE or DONE; Busy covers RUN and FIX; Done pulses once.
module mult_div_unit
  import mdu_pkg::*;
#(
  parameter int DATA_WIDTH = MDU_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  Start,
  input  logic [1:0]            MDUOperation,
  input  logic [DATA_WIDTH-1:0] A,
  input  logic [DATA_WIDTH-1:0] B,
  output logic                  Busy,
  output logic                  Done,
  output logic                  DivByZero,
  output logic [DATA_WIDTH-1:0] HI,
  output logic [DATA_WIDTH-1:0] LO,
  output logic [1:0]            o_dbg_state
);

  localparam int W     = DATA_WIDTH;
  localparam int CNT_W = $clog2(W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(W - 1);

  mdu_state_e         r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [2*W-1:0]     r_acc;
  logic [W-1:0]       r_opb;
  logic               r_is_div;
  logic               r_neg_q;
  logic               r_neg_r;
  logic [W-1:0]       r_hi;
  logic [W-1:0]       r_lo;
  logic               r_busy;
  logic               r_done;
  logic               r_dbz;

  logic               w_sgn;
  logic               w_div_req;
  logic [W-1:0]       w_abs_a;
  logic [W-1:0]       w_abs_b;
  logic [W:0]         w_mul_sum;
  logic [2*W-1:0]     w_mul_next;
  logic [W:0]         w_div_top;
  logic [W:0]         w_div_diff;
  logic [2*W-1:0]     w_div_next;
  logic [2*W-1:0]     w_prod_fix;
  logic [W-1:0]       w_quo_fix;
  logic [W-1:0]       w_rem_fix;

  assign w_sgn     = op_is_signed(MDUOperation);
  assign w_div_req = op_is_div(MDUOperation);

  twos_negate #(.WIDTH(W)) u_abs_a (
    .i_neg (w_sgn & A[W-1]),
    .i_val (A),
    .o_val (w_abs_a)
  );

  twos_negate #(.WIDTH(W)) u_abs_b (
    .i_neg (w_sgn & B[W-1]),
    .i_val (B),
    .o_val (w_abs_b)
  );

  // Multiply: low half holds the remaining multiplier bits, high half the partial product.
  assign w_mul_sum  = {1'b0, r_acc[2*W-1:W]} + (r_acc[0] ? {1'b0, r_opb} : '0);
  assign w_mul_next = {w_mul_sum, r_acc[W-1:1]};

  // Divide: shift {rem, quo} left, trial-subtract the divisor, keep it only if non-negative.
  assign w_div_top  = r_acc[2*W-1:W-1];
  assign w_div_diff = w_div_top - {1'b0, r_opb};
  assign w_div_next = w_div_diff[W] ? {w_div_top[W-1:0], r_acc[W-2:0], 1'b0}
                                    : {w_div_diff[W-1:0], r_acc[W-2:0], 1'b1};

  twos_negate #(.WIDTH(2*W)) u_fix_prod (
    .i_neg (r_neg_q),
    .i_val (r_acc),
    .o_val (w_prod_fix)
  );

  twos_negate #(.WIDTH(W)) u_fix_quo (
    .i_neg (r_neg_q),
    .i_val (r_acc[W-1:0]),
    .o_val (w_quo_fix)
  );

  twos_negate #(.WIDTH(W)) u_fix_rem (
    .i_neg (r_neg_r),
    .i_val (r_acc[2*W-1:W]),
    .o_val (w_rem_fix)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_acc    <= '0;
      r_opb    <= '0;
      r_is_div <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_dbz    <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          r_busy <= 1'b0;
          r_done <= 1'b0;
          r_dbz  <= 1'b0;
          if (Start) begin
            r_cnt    <= '0;
            r_is_div <= w_div_req;
            r_neg_q  <= w_sgn & (A[W-1] ^ B[W-1]);
            r_neg_r  <= w_sgn & A[W-1];
            if (w_div_req && (B == '0)) begin
              // Division by zero short-circuits straight to DONE.
              r_state <= ST_DONE;
              r_done  <= 1'b1;
              r_dbz   <= 1'b1;
              r_hi    <= A;
              r_lo    <= '1;
            end else begin
              r_state <= ST_RUN;
              r_busy  <= 1'b1;
              if (w_div_req) begin
                r_acc <= {{W{1'b0}}, w_abs_a};
                r_opb <= w_abs_b;
              end else begin
                r_acc <= {{W{1'b0}}, w_abs_b};
                r_opb <= w_abs_a;
              end
            end
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_RUN: begin
          r_acc <= r_is_div ? w_div_next : w_mul_next;
          if (r_cnt == CNT_LAST) begin
            r_state <= ST_FIX;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        ST_FIX: begin
          if (r_is_div) begin
            r_hi <= w_rem_fix;
            r_lo <= w_quo_fix;
          end else begin
            r_hi <= w_prod_fix[2*W-1:W];
            r_lo <= w_prod_fix[W-1:0];
          end
          r_state <= ST_DONE;
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign Busy        = r_busy;
  assign Done        = r_done;
  assign DivByZero   = r_dbz;
  assign HI          = r_hi;
  assign LO          = r_lo;
  assign o_dbg_state = r_state;

endmodule
